// File: rtl/gpu_mcnt_ctrl.sv
// Master spectrum counter sequencer with atomic msb/lsb snapshot for software readout.
// Optional build macro GPU_MCNT_AUTO_SNAP_EN adds periodic snapshots every 2^SNAP_LOG2 ticks.
module gpu_mcnt_ctrl #(
   parameter int unsigned MCNT_WIDTH = 48,
   parameter int unsigned SNAP_LOG2  = 20
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   input  logic                  arm,
   input  logic                  sync_in,
   input  logic                  tick,
   input  logic                  snap_req,
   output logic [MCNT_WIDTH-1:0] mcnt,
   output logic                  running,
   output logic                  armed,
   output logic [31:0]           mcnt_msb_out,
   output logic [31:0]           mcnt_lsb_out,
   output logic [31:0]           snap_seq
);

   if (MCNT_WIDTH < 33 || MCNT_WIDTH > 64 || SNAP_LOG2 < 1 || SNAP_LOG2 >= MCNT_WIDTH) begin : g_bad_param
      $error("gpu_mcnt_ctrl: MCNT_WIDTH must be 33..64 and SNAP_LOG2 1..MCNT_WIDTH-1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_arm_d, r_snap_d;
   logic                  w_arm_edge, w_snap_edge;
   logic                  w_snap_fire;
   logic [MCNT_WIDTH-1:0] r_mcnt, w_mcnt_nxt, w_snap_val;
   logic                  r_running, r_armed;
   logic [31:0]           r_msb, r_lsb, r_seq;

   assign w_arm_edge  = arm & ~r_arm_d;
   assign w_snap_edge = snap_req & ~r_snap_d;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_mcnt_nxt  = r_mcnt;
      unique case (r_state)
         ST_IDLE: begin
            if (w_arm_edge) w_state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (sync_in) begin
               w_state_nxt = ST_RUN;
               w_mcnt_nxt  = '0;
            end
         end
         ST_RUN: begin
            // Re-arm takes priority; a tick in the same cycle is dropped.
            if (w_arm_edge)  w_state_nxt = ST_ARMED;
            else if (tick)   w_mcnt_nxt  = r_mcnt + MCNT_WIDTH'(1);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef GPU_MCNT_AUTO_SNAP_EN
   // The low SNAP_LOG2 bits of mcnt are the interval counter: zeroed on RUN entry, stepped by each tick.
   logic w_auto_snap;
   assign w_auto_snap = (r_state == ST_RUN) & ~w_arm_edge & tick & (&r_mcnt[SNAP_LOG2-1:0]);
   assign w_snap_fire = w_snap_edge | w_auto_snap;
   assign w_snap_val  = w_auto_snap ? w_mcnt_nxt : r_mcnt;
`else
   assign w_snap_fire = w_snap_edge;
   assign w_snap_val  = r_mcnt;
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_state   <= ST_IDLE;
         r_arm_d   <= 1'b0;
         r_snap_d  <= 1'b0;
         r_mcnt    <= '0;
         r_running <= 1'b0;
         r_armed   <= 1'b0;
         r_msb     <= '0;
         r_lsb     <= '0;
         r_seq     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_arm_d   <= arm;
         r_snap_d  <= snap_req;
         r_mcnt    <= w_mcnt_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_armed   <= (w_state_nxt == ST_ARMED);
         // Both halves and the sequence number move together so software never sees a torn value.
         if (w_snap_fire) begin
            r_msb <= 32'(w_snap_val[MCNT_WIDTH-1:32]);
            r_lsb <= w_snap_val[31:0];
            r_seq <= r_seq + 32'd1;
         end
      end
   end

   assign mcnt         = r_mcnt;
   assign running      = r_running;
   assign armed        = r_armed;
   assign mcnt_msb_out = r_msb;
   assign mcnt_lsb_out = r_lsb;
   assign snap_seq     = r_seq;

endmodule
